// File: rtl/vdic_dut_2022_pkg.sv
// Shared types for the ALU command sequencer: operation codes, status flags, sequencer states.
package vdic_dut_2022_pkg;

  typedef enum logic [7:0] {
    CMD_NOP = 8'h00,
    CMD_AND = 8'h01,
    CMD_OR  = 8'h02,
    CMD_XOR = 8'h03,
    CMD_ADD = 8'h10,
    CMD_SUB = 8'h20
  } operation_t;

  typedef enum logic [7:0] {
    S_NO_ERROR             = 8'h00,
    S_MISSING_DATA         = 8'h01,
    S_DATA_STACK_OVERFLOW  = 8'h02,
    S_OUTPUT_FIFO_OVERFLOW = 8'h04,
    S_DATA_PARITY_ERROR    = 8'h20,
    S_COMMAND_PARITY_ERROR = 8'h40,
    S_INVALID_COMMAND      = 8'h80
  } stat_t;

  typedef enum logic [2:0] {
    ST_COLLECT = 3'd0,
    ST_CHECK   = 3'd1,
    ST_ISSUE   = 3'd2,
    ST_WAIT    = 3'd3,
    ST_EMIT    = 3'd4
  } seq_state_t;

  // Flags that make the frame unusable: no fold, result forced to zero.
  localparam logic [7:0] ABORT_MASK = 8'h01 | 8'h40 | 8'h80;

  function automatic logic is_known_cmd(input logic [7:0] c);
    case (c)
      CMD_NOP, CMD_AND, CMD_OR, CMD_XOR, CMD_ADD, CMD_SUB: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_operand_stack.sv
// Operand store for one frame: append-only push, bulk clear, random-access read.
module alu_operand_stack #(
  parameter int unsigned DEPTH = 9,
  parameter int unsigned W     = 16,
  parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [W-1:0]  data_i,
  input  logic          clear_i,
  input  logic [CW-1:0] rd_idx_i,
  output logic [W-1:0]  rd_data_o,
  output logic [CW-1:0] count_o,
  output logic          full_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [CW-1:0] count_q;

  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;

  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      count_q <= '0;
    end else if (push_i && !full_o) begin
      count_q <= count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !full_o) begin
      mem_q[AW'(count_q)] <= data_i;
    end
  end

  always_comb begin
    rd_data_o = '0;
    if (rd_idx_i < CW'(DEPTH)) begin
      rd_data_o = mem_q[AW'(rd_idx_i)];
    end
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Collects data words and a command, folds the words through an external ALU, emits one result frame.
module alu_cmd_sequencer
  import vdic_dut_2022_pkg::*;
#(
  parameter int unsigned STACK_DEPTH = 9,
  parameter int unsigned DW          = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW-1:0]   in_data,
  input  logic            in_ctl,
  input  logic            in_par,
  output logic            alu_req,
  input  logic            alu_ack,
  output logic [7:0]      alu_op,
  output logic [2*DW-1:0] alu_a,
  output logic [2*DW-1:0] alu_b,
  input  logic [2*DW-1:0] alu_result,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2*DW-1:0] out_data,
  output logic [7:0]      out_status
);

  localparam int unsigned RW = 2 * DW;
  localparam int unsigned CW = $clog2(STACK_DEPTH + 1);

  seq_state_t    state_q, state_d;
  logic [7:0]    cmd_q, cmd_d;
  logic [7:0]    flags_q, flags_d;
  logic [RW-1:0] acc_q, acc_d;
  logic [CW-1:0] idx_q, idx_d;

  logic          stk_push, stk_clear, stk_full;
  logic [CW-1:0] stk_rd_idx, stk_count;
  logic [RW-1:0] stk_rd_data;

  logic          in_fire, par_err;
  logic [7:0]    chk_flags;

  alu_operand_stack #(
    .DEPTH (STACK_DEPTH),
    .W     (RW),
    .CW    (CW)
  ) u_stack (
    .clk       (clk),
    .rst       (rst),
    .push_i    (stk_push),
    .data_i    (RW'(in_data)),
    .clear_i   (stk_clear),
    .rd_idx_i  (stk_rd_idx),
    .rd_data_o (stk_rd_data),
    .count_o   (stk_count),
    .full_o    (stk_full)
  );

  assign in_fire    = in_valid && (state_q == ST_COLLECT);
  assign par_err    = ^{in_par, in_ctl, in_data};
  assign stk_rd_idx = (state_q == ST_CHECK) ? '0 : idx_q;

  always_comb begin
    chk_flags = flags_q;
    if (!is_known_cmd(cmd_q)) chk_flags = chk_flags | 8'(S_INVALID_COMMAND);
    if (stk_count < CW'(2))   chk_flags = chk_flags | 8'(S_MISSING_DATA);
  end

  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    flags_d   = flags_q;
    acc_d     = acc_q;
    idx_d     = idx_q;
    stk_push  = 1'b0;
    stk_clear = 1'b0;

    case (state_q)
      ST_COLLECT: begin
        if (in_fire) begin
          if (in_ctl) begin
            cmd_d   = in_data;
            state_d = ST_CHECK;
            if (par_err) flags_d = flags_d | 8'(S_COMMAND_PARITY_ERROR);
          end else begin
            if (stk_full) flags_d = flags_d | 8'(S_DATA_STACK_OVERFLOW);
            else          stk_push = 1'b1;
            if (par_err) flags_d = flags_d | 8'(S_DATA_PARITY_ERROR);
          end
        end
      end

      // Overflow and data-parity flags are reported but still let the fold run.
      ST_CHECK: begin
        flags_d = chk_flags;
        if ((chk_flags & ABORT_MASK) != 8'h00) begin
          acc_d   = '0;
          state_d = ST_EMIT;
        end else if (cmd_q == CMD_NOP) begin
          if (chk_flags != 8'h00) begin
            acc_d   = '0;
            state_d = ST_EMIT;
          end else begin
            stk_clear = 1'b1;
            state_d   = ST_COLLECT;
          end
        end else begin
          acc_d   = stk_rd_data;
          idx_d   = CW'(1);
          state_d = ST_ISSUE;
        end
      end

      ST_ISSUE: state_d = ST_WAIT;

      ST_WAIT: begin
        if (alu_ack) begin
          acc_d   = alu_result;
          idx_d   = idx_q + 1'b1;
          state_d = ((idx_q + 1'b1) == stk_count) ? ST_EMIT : ST_ISSUE;
        end
      end

      ST_EMIT: begin
        if (out_ready) begin
          stk_clear = 1'b1;
          flags_d   = '0;
          acc_d     = '0;
          idx_d     = '0;
          state_d   = ST_COLLECT;
        end
      end

      default: state_d = ST_COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_COLLECT;
      cmd_q   <= '0;
      flags_q <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      flags_q <= flags_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
    end
  end

  assign in_ready   = (state_q == ST_COLLECT);
  assign alu_req    = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
  assign alu_op     = cmd_q;
  assign alu_a      = acc_q;
  assign alu_b      = stk_rd_data;
  assign out_valid  = (state_q == ST_EMIT);
  assign out_data   = out_valid ? acc_q : '0;
  assign out_status = out_valid ? flags_q : '0;

endmodule
